noc_inject_arb: RTL and testbench
=================================

NOC_INJECT_ARB -- requirements
Module: noc_inject_arb

Interface
REQ-001 Parameter WIDTH, default 32, data flit width.
REQ-002 Parameter N, default 16, number of NoC nodes.
REQ-003 Parameter N_ADDR_WIDTH, default $clog2(N), router address width.
REQ-004 Parameter NREQ, default 4, number of traffic sources sharing one NoC injection port (2..16).
REQ-005 Parameter MAX_BURST, default 4, maximum consecutive accepted flits per grant (1..255).
REQ-006 clk  input  1  sole clock; all state updates on posedge clk.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 req_data_in  input  NREQ*WIDTH  flit from requester i at bits [i*WIDTH +: WIDTH].
REQ-009 req_dest_in  input  NREQ*N_ADDR_WIDTH  destination router of requester i, same packing.
REQ-010 req_valid_in  input  NREQ  requester i presents a flit.
REQ-011 req_ready_out  output  NREQ  arbiter accepts from requester i this cycle.
REQ-012 data_out  output  WIDTH  flit to the NoC port.
REQ-013 dest_out  output  N_ADDR_WIDTH  destination to the NoC port.
REQ-014 valid_out  output  1  data_out/dest_out valid.
REQ-015 ready_in  input  1  NoC port accepts flit this cycle.
REQ-016 grant_id_out  output  $clog2(NREQ)  index of the currently or most recently granted requester.

Function
REQ-017 A transfer occurs on any interface when valid and ready are both high in the same cycle; valid_out is never gated by ready_in.
REQ-018 Output stage is one register holding data_out, dest_out, valid_out; it may load when valid_out=0 or ready_in=1 (slot free).
REQ-019 FSM states are IDLE and BURST.
REQ-020 In IDLE, req_ready_out is all-zero; if any req_valid_in bit is high, the FSM selects the first valid index searching upward from rr_ptr with wrap, loads grant_id_out, clears burst_cnt, and enters BURST next cycle (one arbitration bubble per grant).
REQ-021 In BURST, req_ready_out[grant_id_out] = slot free; all other bits are 0.
REQ-022 On an accepted flit, the selected requester's data and dest load into the output register and valid_out=1 next cycle (latency 1 cycle); burst_cnt increments.
REQ-023 If the slot is free and nothing is accepted, valid_out clears next cycle; if the slot is not free, the output register holds its value unchanged.
REQ-024 BURST->IDLE when a flit is accepted with burst_cnt = MAX_BURST-1, or when req_valid_in[grant_id_out]=0 while the slot is free; in both cases rr_ptr = (grant_id_out+1) mod NREQ.
REQ-025 While the slot is not free (backpressure), BURST holds state regardless of the requester's valid, and burst_cnt does not change.
REQ-026 rr_ptr wraps from NREQ-1 to 0; a single active requester is re-granted after its bubble.
REQ-027 No flit is duplicated or dropped: every accepted requester flit appears exactly once on the output, in acceptance order.

Reset
REQ-028 While rst=0 at posedge clk: state=IDLE, valid_out=0, req_ready_out=0, rr_ptr=0, grant_id_out=0, burst_cnt=0; data_out and dest_out are 0.
REQ-029 Reset mid-burst discards any held output flit; operation resumes from IDLE on the first cycle with rst=1.

Structure
REQ-030 The FSM state enum and the burst counter width constant live in shared package lynx_arb_pkg.
REQ-031 The rotating-priority first-valid search is the sub-module rr_pick: combinational, inputs valid vector and pointer, outputs index and found.

Verification (NREQ=4, MAX_BURST=4, ready_in=1 unless stated)
REQ-032 Only requester 1 valid continuously -> output pattern is 4 flits, 1 bubble, repeated; grant_id_out=1 throughout.
REQ-033 All four requesters valid continuously -> grants 0,1,2,3,0 with 4 flits each; rr_ptr wraps from 3 to 0.
REQ-034 ready_in=0 for 3 cycles while valid_out=1 -> data_out/dest_out are stable, req_ready_out=0000, and the burst resumes with no flit lost.
REQ-035 Requester 0 drops valid after 2 accepted flits, requesters 2 and 3 valid -> IDLE, then grant goes to 2 (pointer 1, requester 1 idle).
REQ-036 rst=0 asserted during the 3rd flit of a burst -> the next cycle shows valid_out=0, req_ready_out=0000, and the first grant after reset starts search from index 0.
REQ-037 Scoreboard on all runs: per-requester sequence counters embedded in data are strictly increasing on the output, and dest_out matches the requester's dest.

Source files
------------

// File: rtl/lynx_arb_pkg.sv
// ---------------------------------------------------------------------------
// lynx_arb_pkg
// Shared definitions for the NoC injection arbiter.
//   arb_state_e  : arbiter FSM states (IDLE = arbitrate, BURST = stream)
//   BURST_CNT_W  : width of the per-grant flit counter; 8 bits covers a
//                  MAX_BURST of up to 255 accepted flits per grant.
// ---------------------------------------------------------------------------
package lynx_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    localparam int BURST_CNT_W = 8;

endpackage : lynx_arb_pkg

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority search: returns the first asserted bit of
// valid_in found by searching upward from ptr_in, wrapping past NREQ-1.
// Ports:
//   valid_in  [NREQ]  : request vector
//   ptr_in    [IDX_W] : index with highest priority (must be < NREQ)
//   idx_out   [IDX_W] : selected index (0 when nothing is found)
//   found_out         : at least one bit of valid_in is set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  valid_in,
    input  logic [IDX_W-1:0] ptr_in,
    output logic [IDX_W-1:0] idx_out,
    output logic             found_out
);

    localparam logic [IDX_W:0] NREQ_W = (IDX_W + 1)'(NREQ);

    // cand_idx[k] is the requester sitting k positions after the pointer.
    logic [IDX_W-1:0] cand_idx   [NREQ];
    logic [NREQ-1:0]  cand_valid;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            logic [IDX_W:0] wrapped;
            assign sum          = {1'b0, ptr_in} + (IDX_W + 1)'(gi);
            // One conditional subtract is enough since ptr_in < NREQ and gi < NREQ.
            assign wrapped      = (sum >= NREQ_W) ? (sum - NREQ_W) : sum;
            assign cand_idx[gi] = wrapped[IDX_W-1:0];
            assign cand_valid[gi] = valid_in[cand_idx[gi]];
        end
    endgenerate

    // Scan from the far end so the nearest candidate to the pointer wins.
    always_comb begin
        idx_out   = '0;
        found_out = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_valid[k]) begin
                idx_out   = cand_idx[k];
                found_out = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/noc_inject_arb.sv
// ---------------------------------------------------------------------------
// noc_inject_arb
// Shares one NoC injection port between NREQ traffic sources. A round-robin
// pick in IDLE grants one requester, which may then stream up to MAX_BURST
// flits (BURST) through a single output register before the grant rotates.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   req_data_in     : NREQ packed flits, requester i at [i*WIDTH +: WIDTH]
//   req_dest_in     : NREQ packed destinations, same packing
//   req_valid_in    : per-requester valid
//   req_ready_out   : per-requester ready (only the granted bit can be set)
//   data_out        : flit to NoC port
//   dest_out        : destination router to NoC port
//   valid_out       : output register holds a flit
//   ready_in        : NoC port accepts the flit this cycle
//   grant_id_out    : currently / most recently granted requester
// ---------------------------------------------------------------------------
module noc_inject_arb
    import lynx_arb_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int N            = 16,
    parameter int N_ADDR_WIDTH = $clog2(N),
    parameter int NREQ         = 4,
    parameter int MAX_BURST    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ*WIDTH-1:0]        req_data_in,
    input  logic [NREQ*N_ADDR_WIDTH-1:0] req_dest_in,
    input  logic [NREQ-1:0]              req_valid_in,
    output logic [NREQ-1:0]              req_ready_out,
    output logic [WIDTH-1:0]             data_out,
    output logic [N_ADDR_WIDTH-1:0]      dest_out,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic [$clog2(NREQ)-1:0]      grant_id_out
);

    localparam int                     IDX_W     = $clog2(NREQ);
    localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(NREQ - 1);
    localparam logic [BURST_CNT_W-1:0] LAST_BEAT = BURST_CNT_W'(MAX_BURST - 1);

    // State
    arb_state_e              state_q,     state_d;
    logic [IDX_W-1:0]        rr_ptr_q,    rr_ptr_d;
    logic [IDX_W-1:0]        grant_q,     grant_d;
    logic [BURST_CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [WIDTH-1:0]        data_q,      data_d;
    logic [N_ADDR_WIDTH-1:0] dest_q,      dest_d;
    logic                    valid_q,     valid_d;

    // Unpacked views of the requester buses
    logic [WIDTH-1:0]        req_data_arr [NREQ];
    logic [N_ADDR_WIDTH-1:0] req_dest_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_data_arr[gi] = req_data_in[gi*WIDTH +: WIDTH];
            assign req_dest_arr[gi] = req_dest_in[gi*N_ADDR_WIDTH +: N_ADDR_WIDTH];
        end
    endgenerate

    // Handshake terms
    logic             slot_free;
    logic             grant_valid;
    logic             accept;
    logic             burst_last;
    logic             burst_end;
    logic [IDX_W-1:0] grant_next;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;

    // The output register can take a new flit when empty or being drained.
    assign slot_free   = !valid_q || ready_in;
    assign grant_valid = req_valid_in[grant_q];
    assign accept      = (state_q == ST_BURST) && slot_free && grant_valid;
    assign burst_last  = (burst_cnt_q == LAST_BEAT);
    // A grant ends on its final accepted flit, or when the owner has nothing
    // to send while it could have. Under backpressure the grant is frozen.
    assign burst_end   = (state_q == ST_BURST) && slot_free && (!grant_valid || burst_last);
    assign grant_next  = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .valid_in  (req_valid_in),
        .ptr_in    (rr_ptr_q),
        .idx_out   (pick_idx),
        .found_out (pick_found)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            data_q      <= '0;
            dest_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            data_q      <= data_d;
            dest_q      <= dest_d;
            valid_q     <= valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (pick_found) state_d = ST_BURST;
            ST_BURST: if (burst_end)  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs and datapath
    always_comb begin
        req_ready_out = '0;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        burst_cnt_d   = burst_cnt_q;
        data_d        = data_q;
        dest_d        = dest_q;
        valid_d       = valid_q;

        if (state_q == ST_BURST) begin
            req_ready_out[grant_q] = slot_free;
        end

        // Output register: load on accept, empty when free and idle, else hold.
        if (slot_free) begin
            valid_d = accept;
            if (accept) begin
                data_d = req_data_arr[grant_q];
                dest_d = req_dest_arr[grant_q];
            end
        end

        if (state_q == ST_IDLE) begin
            if (pick_found) begin
                grant_d     = pick_idx;
                burst_cnt_d = '0;
            end
        end else begin
            if (accept) begin
                burst_cnt_d = burst_cnt_q + BURST_CNT_W'(1);
            end
            if (burst_end) begin
                rr_ptr_d = grant_next;
            end
        end
    end

    assign data_out     = data_q;
    assign dest_out     = dest_q;
    assign valid_out    = valid_q;
    assign grant_id_out = grant_q;

endmodule : noc_inject_arb

// File: tb/tb_noc_inject_arb.sv
// ---------------------------------------------------------------------------
// tb_noc_inject_arb
// Directed scenarios for the injection arbiter (NREQ=4, MAX_BURST=4). Each
// requester sends {id[7:0], seq[23:0]} with a fixed destination. Accepted
// flits are pushed to a scoreboard queue; a monitor pops and compares every
// flit leaving the output port.
// ---------------------------------------------------------------------------
module tb_noc_inject_arb;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int AW    = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ*WIDTH-1:0] req_data_in;
    logic [NREQ*AW-1:0]    req_dest_in;
    logic [NREQ-1:0]       req_valid_in;
    logic [NREQ-1:0]       req_ready_out;
    logic [WIDTH-1:0]      data_out;
    logic [AW-1:0]         dest_out;
    logic                  valid_out;
    logic                  ready_in;
    logic [1:0]            grant_id_out;

    noc_inject_arb #(
        .WIDTH        (WIDTH),
        .N            (16),
        .N_ADDR_WIDTH (AW),
        .NREQ         (NREQ),
        .MAX_BURST    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_data_in   (req_data_in),
        .req_dest_in   (req_dest_in),
        .req_valid_in  (req_valid_in),
        .req_ready_out (req_ready_out),
        .data_out      (data_out),
        .dest_out      (dest_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .grant_id_out  (grant_id_out)
    );

    always #5 clk = ~clk;

    int              n_checks = 0;
    int              n_pass   = 0;
    int              seq      [NREQ];
    int              acc_cnt  [NREQ];
    int              last_seq [NREQ];
    logic [NREQ-1:0] acc_mask;
    logic [35:0]     exp_q    [$];
    logic [7:0]      out_ids  [$];

    function automatic logic [3:0] dest_of(input int i);
        return 4'((i * 5 + 3) % 16);
    endfunction

    task automatic check(input string name, input logic ok,
                         input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Requester payloads follow their sequence counters.
    always_comb begin
        req_data_in = '0;
        req_dest_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_data_in[i*WIDTH +: WIDTH] = {8'(i), seq[i][23:0]};
            req_dest_in[i*AW +: AW]       = dest_of(i);
        end
    end

    // Advance a requester's sequence after its flit was taken.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) if (acc_mask[i]) seq[i]++;
        acc_mask = '0;
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [35:0] e;
        int          id;
        int          s;
        if (valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 1'b0, {28'b0, dest_out, data_out}, 64'b0);
            end else begin
                e = exp_q.pop_front();
                check("sb_flit", {dest_out, data_out} == e, {28'b0, dest_out, data_out}, {28'b0, e});
                id = int'(data_out[31:24]);
                s  = int'(data_out[23:0]);
                if (id < NREQ) begin
                    check("sb_seq_dest", (s > last_seq[id]) && (dest_out == dest_of(id)),
                          {28'b0, dest_out, data_out}, {28'b0, dest_of(id), 32'(last_seq[id] + 1)});
                    last_seq[id] = s;
                end
                out_ids.push_back(data_out[31:24]);
            end
        end
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid_in[i] && req_ready_out[i]) begin
                    exp_q.push_back({dest_of(i), req_data_in[i*WIDTH +: WIDTH]});
                    acc_mask[i] = 1'b1;
                    acc_cnt[i]++;
                end
            end
        end else begin
            // Whatever is held at a reset edge is discarded by the design.
            exp_q.delete();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        req_valid_in = '0;
        ready_in     = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("reset_state",
              !valid_out && req_ready_out == 4'b0 && grant_id_out == 2'd0 &&
              data_out == 32'b0 && dest_out == 4'b0,
              {27'b0, valid_out, req_ready_out, grant_id_out, data_out},
              64'b0);
        tick();
        rst = 1'b1;
    endtask

    task automatic drain();
        req_valid_in = '0;
        ready_in     = 1'b1;
        repeat (8) tick();
        check("drain_empty", exp_q.size() == 0, 64'(exp_q.size()), 64'b0);
    endtask

    initial begin
        logic [11:0] pat;
        logic        gok;
        logic        seen;
        logic [31:0] hd;
        logic [3:0]  hs;
        int          base;

        rst          = 1'b0;
        ready_in     = 1'b1;
        req_valid_in = '0;
        acc_mask     = '0;
        for (int i = 0; i < NREQ; i++) begin
            seq[i]      = 0;
            acc_cnt[i]  = 0;
            last_seq[i] = -1;
        end

        // All four requesters busy: grants 0,1,2,3,0 with four flits each.
        do_reset();
        out_ids.delete();
        req_valid_in = 4'hF;
        for (int c = 0; c < 60 && out_ids.size() < 20; c++) tick();
        check("rr_collect", out_ids.size() >= 20, 64'(out_ids.size()), 64'd20);
        req_valid_in = '0;
        for (int k = 0; k < 20 && k < out_ids.size(); k++)
            check("rr_grant_seq", out_ids[k] == 8'((k / 4) % 4), 64'(out_ids[k]), 64'((k / 4) % 4));
        drain();

        // Only requester 1: four flits then one bubble, repeated.
        do_reset();
        req_valid_in = 4'b0010;
        pat = '0;
        gok = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            pat = {pat[10:0], valid_out};
            if (c >= 1 && grant_id_out != 2'd1) gok = 1'b0;
        end
        check("single_req_pattern", pat == 12'b001111011110, 64'(pat), 64'b001111011110);
        check("single_req_grant", gok, 64'(grant_id_out), 64'd1);
        tick();
        drain();

        // Backpressure for three cycles while a flit is held.
        do_reset();
        req_valid_in = 4'b0100;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (valid_out) seen = 1'b1;
        end
        check("bp_first_valid", seen, 64'(seen), 64'd1);
        tick();
        ready_in = 1'b0;
        hd = '0;
        hs = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_valid_noready", valid_out && req_ready_out == 4'b0,
                  {59'b0, valid_out, req_ready_out}, 64'b10000);
            if (c == 0) begin
                hd = data_out;
                hs = dest_out;
            end else begin
                check("bp_stable", data_out == hd && dest_out == hs,
                      {28'b0, dest_out, data_out}, {28'b0, hs, hd});
            end
        end
        tick();
        ready_in = 1'b1;
        repeat (10) tick();
        drain();

        // Requester 0 drops after two flits; 2 and 3 waiting, 1 idle.
        do_reset();
        base = acc_cnt[0];
        req_valid_in = 4'b1101;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (acc_cnt[0] - base >= 2) seen = 1'b1;
        end
        check("drop_wait", seen, 64'(acc_cnt[0] - base), 64'd2);
        req_valid_in = 4'b1100;
        @(negedge clk);
        @(negedge clk);
        check("drop_bubble", req_ready_out == 4'b0000, 64'(req_ready_out), 64'b0);
        @(negedge clk);
        check("drop_regrant", grant_id_out == 2'd2 && req_ready_out == 4'b0100,
              {58'b0, grant_id_out, req_ready_out}, {58'b0, 2'd2, 4'b0100});
        tick();
        check("drop_count", acc_cnt[0] - base == 2, 64'(acc_cnt[0] - base), 64'd2);
        drain();

        // Reset during the 3rd flit of requester 1's second burst.
        do_reset();
        base = acc_cnt[1];
        req_valid_in = 4'b0010;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (acc_cnt[1] - base >= 6) seen = 1'b1;
        end
        check("rst_wait", seen, 64'(acc_cnt[1] - base), 64'd6);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_burst", !valid_out && req_ready_out == 4'b0 && data_out == 32'b0,
              {27'b0, valid_out, req_ready_out, data_out}, 64'b0);
        tick();
        rst = 1'b1;
        req_valid_in = 4'b1001;
        out_ids.delete();
        @(negedge clk);
        @(negedge clk);
        check("rst_first_grant", grant_id_out == 2'd0 && req_ready_out == 4'b0001,
              {58'b0, grant_id_out, req_ready_out}, {58'b0, 2'd0, 4'b0001});
        tick();
        drain();
        check("rst_first_flit", out_ids.size() > 0 && out_ids[0] == 8'd0,
              (out_ids.size() > 0) ? 64'(out_ids[0]) : 64'hFF, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_noc_inject_arb
